// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back path (package riscv_pkg).
// Requester indices name the producers wired to the write-back arbiter.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREQ_DEFAULT = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    REQ_ALU   = 3'd0,
    REQ_ARITH = 3'd1,
    REQ_COMM  = 3'd2
  } req_id_e;

  // Round-robin successor of idx within 0..n-1.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side write-back bus: per-requester valid/ready plus packed addr/data slices.
// Requester i drives req_addr[i*AW +: AW] and req_data[i*XLEN +: XLEN].
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick: first valid index scanning from ptr upward (mod N).
// Produces a one-hot grant, its index, and an any-grant flag; en=0 forces no grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = PW'(sum);
      if (en && !found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    any = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port: round-robin grant, registered port, x0 drop.
// Define REGFILE_WB_FWD_EN to build the in-flight-write bypass onto the two read ports.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_arbiter_if.slave      wb,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [2:0]               grant_id,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2
);

  import riscv_pkg::*;

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  rr_arbiter #(.N(NREQ)) u_rr (
    .valid     (wb.req_valid),
    .ptr       (ptr),
    .en        (!rf_hold && !rst),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign wb.req_ready = grant;
  assign xfer         = grant_any;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = wb.req_addr[i*AW +: AW];
        sel_data = wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are consumed (ready, ptr advances) but never reach WE3.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
    end else begin
      rf_we <= xfer && (sel_addr != AW'(REG_ZERO));
      if (xfer) begin
        ptr      <= PW'(rr_next(int'(grant_idx), NREQ));
        rf_addr  <= sel_addr;
        rf_wdata <= sel_data;
        grant_id <= 3'(grant_idx);
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1  = rf_we && (rf_addr != AW'(REG_ZERO)) && (rd_addr1 == rf_addr);
  assign fwd_hit2  = rf_we && (rf_addr != AW'(REG_ZERO)) && (rd_addr2 == rf_addr);
  assign fwd_data1 = fwd_hit1 ? rf_wdata : '0;
  assign fwd_data2 = fwd_hit2 ? rf_wdata : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go to a scoreboard queue at acceptance
// and are popped when the write port is sampled one cycle later.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic [2:0]      id;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            rf_hold;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XLEN-1:0] rf_wdata;
  logic [2:0]      grant_id;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [XLEN-1:0] fwd_data1;
  logic [XLEN-1:0] fwd_data2;

  logic [AW-1:0]   addr [NREQ];
  logic [XLEN-1:0] data [NREQ];

  wr_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) wb ();

  assign wb.req_addr = {addr[2], addr[1], addr[0]};
  assign wb.req_data = {data[2], data[1], data[0]};

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rf_hold   (rf_hold),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check ready mid-cycle, push the expected write, check the port after the edge.
  task automatic step(input logic [2:0] v, input logic h, input logic [2:0] er, input string tag);
    logic            exp_we;
    logic            eh1, eh2;
    logic [XLEN-1:0] ed1, ed2;
    int              gi;
    wr_t             w;
    wb.req_valid = v;
    rf_hold      = h;
    exp_we       = 1'b0;
    eh1 = 1'b0; eh2 = 1'b0; ed1 = '0; ed2 = '0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(wb.req_ready), 32'(er));
    if (er != 3'b000) begin
      gi = er[0] ? 0 : (er[1] ? 1 : 2);
      if (addr[gi] != '0) begin
        q.push_back('{a: addr[gi], d: data[gi], id: 3'(gi)});
        exp_we = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      w = q.pop_front();
      chk({tag, ".rf_addr"},  32'(rf_addr),  32'(w.a));
      chk({tag, ".rf_wdata"}, rf_wdata,      w.d);
      chk({tag, ".grant_id"}, 32'(grant_id), 32'(w.id));
`ifdef REGFILE_WB_FWD_EN
      eh1 = (rd_addr1 == w.a);
      eh2 = (rd_addr2 == w.a);
      ed1 = eh1 ? w.d : '0;
      ed2 = eh2 ? w.d : '0;
`endif
    end
    chk({tag, ".fwd_hit1"},  32'(fwd_hit1), 32'(eh1));
    chk({tag, ".fwd_hit2"},  32'(fwd_hit2), 32'(eh2));
    chk({tag, ".fwd_data1"}, fwd_data1,     ed1);
    chk({tag, ".fwd_data2"}, fwd_data2,     ed2);
  endtask

  initial begin
    rst          = 1'b1;
    rf_hold      = 1'b0;
    wb.req_valid = '0;
    rd_addr1     = 5'd2;
    rd_addr2     = 5'd0;
    addr[0] = 5'd1;  addr[1] = 5'd2;  addr[2] = 5'd3;
    data[0] = 32'd10; data[1] = 32'd20; data[2] = 32'd30;

    // Reset held two cycles with every requester valid.
    step(3'b111, 1'b0, 3'b000, "rst0");
    step(3'b111, 1'b0, 3'b000, "rst1");
    chk("rst.rf_addr",  32'(rf_addr),  32'd0);
    chk("rst.rf_wdata", rf_wdata,      32'd0);
    chk("rst.grant_id", 32'(grant_id), 32'd0);

    // Contention straight out of reset: 0,1,2,0,1,2 with WE3 high every cycle.
    rst = 1'b0;
    step(3'b111, 1'b0, 3'b001, "cont0");
    step(3'b111, 1'b0, 3'b010, "cont1");
    step(3'b111, 1'b0, 3'b100, "cont2");
    step(3'b111, 1'b0, 3'b001, "cont3");
    step(3'b111, 1'b0, 3'b010, "cont4");
    step(3'b111, 1'b0, 3'b100, "cont5");
    step(3'b000, 1'b0, 3'b000, "idle0");

    // x0 write is accepted but dropped; ptr moves to 1.
    addr[0] = 5'd0;
    step(3'b001, 1'b0, 3'b001, "x0");

    // Single write from requester 1; ptr 1 -> 2.
    addr[1] = 5'd5;
    step(3'b010, 1'b0, 3'b010, "single");
    step(3'b000, 1'b0, 3'b000, "after_single");

    // Hold three cycles then release: requester 2 wins, ptr wraps to 0.
    step(3'b100, 1'b1, 3'b000, "hold0");
    step(3'b100, 1'b1, 3'b000, "hold1");
    step(3'b100, 1'b1, 3'b000, "hold2");
    step(3'b100, 1'b0, 3'b100, "release");

    // ptr must be 0 now; write x2 = 30 with rd_addr1=2 for the bypass.
    addr[0] = 5'd2;
    data[0] = 32'd30;
    step(3'b111, 1'b0, 3'b001, "fwd1");

    // ptr 1: requester 1 writes x5 while rd_addr2 reads x5.
    rd_addr2 = 5'd5;
    step(3'b011, 1'b0, 3'b010, "fwd2");
    step(3'b000, 1'b0, 3'b000, "idle1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32 x 32-bit register file write port (WE3/A3/WD3). Up to NREQ producers compete for the single write port through valid/ready handshakes: the single-cycle ALU path, the multi-cycle arithmetic units and the communication-peripheral load path. Grants are round-robin, registered onto the write port and suppressed for x0. An optional bypass supplies an in-flight write to the two read ports (A1/A2).

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_addr  in  NREQ*AW  destination register; requester i uses slice [i*AW +: AW]
- req_data  in  NREQ*XLEN  write data; requester i uses slice [i*XLEN +: XLEN]
- rf_hold  in  1  freeze the write port (debug/config); no grants while high
- rf_we  out  1  to register file WE3
- rf_addr  out  AW  to register file A3
- rf_wdata  out  XLEN  to register file WD3
- grant_id  out  3  index of the requester whose write is on the port; valid when rf_we=1
- rd_addr1, rd_addr2  in  AW each  register-file read addresses (A1, A2)
- fwd_hit1, fwd_hit2  out  1 each  in-flight write matches the read address
- fwd_data1, fwd_data2  out  XLEN each  forwarded data

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge. After raising valid, requester i holds valid, addr and data stable until ready. req_ready is combinational from req_valid, ptr, rf_hold and rst. Requesters must not make req_valid depend on req_ready.
- Arbitration: the winner is the first valid requester scanning i = ptr, ptr+1, … (mod NREQ). At most one req_ready is high, and only for that winner. No winner while rf_hold=1 or rst=1.
- ptr update: on a transfer by i, ptr <= (i+1) mod NREQ. Otherwise ptr holds, including across rf_hold.
- Output stage: on a transfer, the next cycle has rf_we=1, rf_addr=req_addr[i], rf_wdata=req_data[i] and grant_id=i. With no transfer, the next cycle has rf_we=0; rf_addr, rf_wdata and grant_id hold their last values.
- x0: a transfer with addr=0 is accepted (ready=1, ptr advances) but rf_we stays 0 the next cycle.
- Fairness: a continuously valid requester is granted within NREQ cycles of asserting valid, provided rf_hold stays low.
- Reset values: rf_we=0, rf_addr=0, rf_wdata=0, grant_id=0, ptr=0. req_ready=0 while rst=1.
- Reset mid-operation: a write already on the port during the rst cycle still lands, because the register file samples at that same edge. Requests not yet accepted are lost. Requesters restart their handshakes after reset.

## Timing
- Latency: acceptance at edge N; rf_we high during cycle N+1; register file updated at edge N+1.
- Throughput: one write per cycle. rf_we can stay high back-to-back.
- rf_hold asserted in cycle N: no acceptance at edge N, so rf_we=0 in cycle N+1. A write already on the port in cycle N still completes.
- Simultaneous valids: resolved by ptr only. Requests that lose keep waiting, with valid held.

## Configuration
- REGFILE_WB_FWD_EN defined:
  - fwd_hitk = rf_we && (rf_addr != 0) && (rd_addrk == rf_addr).
  - fwd_datak = rf_wdata when fwd_hitk=1, else 0.
  - Purely combinational; no added latency.
- REGFILE_WB_FWD_EN undefined: the fwd ports remain, tied to 0. No compare logic is built.

## Structure
- Shared package (riscv_pkg):
  - XLEN and AW constants.
  - REG_ZERO = 5'd0.
  - A requester-index enum: REQ_ALU=0, REQ_ARITH=1, REQ_COMM=2.
- One sub-module: rr_arbiter (NREQ-wide round-robin pick from valid vector and ptr, one-hot grant out). It is reusable for bus arbitration elsewhere.
- Top level holds ptr, the output register stage and the forwarding compares.

## Test plan
- Reset: rst=1 for 2 cycles with all valids high -> req_ready=0, rf_we=0, rf_addr=0, rf_wdata=0. First cycle after release: req_ready=3'b001.
- Single write: req_valid=3'b010, addr 5, data 20 -> req_ready=3'b010 that cycle. Next cycle rf_we=1, rf_addr=5, rf_wdata=20, grant_id=1. Cycle after: rf_we=0.
- Contention: all three valid for 6 cycles, addrs 1/2/3, data 10/20/30 -> grant_id sequence 0,1,2,0,1,2; rf_we continuously high.
- x0 drop: requester 0, addr 0, data 10 -> req_ready[0]=1, ptr becomes 1, rf_we stays 0. A read of x0 returns 0.
- Hold: rf_hold=1 for 3 cycles with req_valid=3'b100 -> req_ready=0, rf_we=0. Release -> grant to 2 next cycle, data written, then ptr=0.
- Forwarding (REGFILE_WB_FWD_EN): addr 2, data 30 on the port, rd_addr1=2, rd_addr2=0 -> fwd_hit1=1, fwd_data1=30, fwd_hit2=0. With the macro off, all fwd outputs are 0.
